// File: rtl/mvm_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : mvm_result_drain
// Description : Captures the result words a matrix-vector multiplier streams
//               after its done pulse, buffers them, and replays them on a
//               valid/ready stream saturated to a narrower signed width.
//               Reports idle to the upstream controller and flags done pulses
//               that arrive while a job is still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_result_drain #(
    parameter int MAT_SCALE = 3,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        done_in,
    input  logic signed [IN_WIDTH-1:0]  y_in,
    output logic        [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        out_sat,
    output logic                        idle,
    output logic                        err_overrun
);

    localparam int IDX_W = (MAT_SCALE > 1) ? $clog2(MAT_SCALE) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(MAT_SCALE - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t                     state_q;
    logic [IDX_W-1:0]           wr_q;
    logic [IDX_W-1:0]           rd_q;
    logic                       out_valid_q;
    logic                       out_last_q;
    logic                       idle_q;
    logic                       err_q;
    logic signed [IN_WIDTH-1:0] buf_q [MAT_SCALE];

    logic                       buf_we_d;
    logic [IDX_W-1:0]           buf_idx_d;
    logic signed [IN_WIDTH-1:0] rd_word_d;
    logic [OUT_WIDTH-1:0]       sat_data_d;
    logic                       sat_flag_d;

    // Word 0 lands with the done pulse; later words land at the write index.
    always_comb begin
        buf_we_d  = 1'b0;
        buf_idx_d = wr_q;
        if (state_q == S_IDLE) begin
            buf_we_d  = done_in;
            buf_idx_d = '0;
        end else if (state_q == S_CAPTURE) begin
            buf_we_d  = 1'b1;
        end
    end

    // Result buffer; contents are meaningless until a job is captured, so no reset.
    always_ff @(posedge clk) begin
        if (buf_we_d) begin
            buf_q[buf_idx_d] <= y_in;
        end
    end

    // Capture/drain sequencer with registered status and handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_q        <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            idle_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            // A done pulse is only legal while idle; anything else is sticky.
            if (done_in && (state_q != S_IDLE)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (done_in) begin
                        wr_q   <= C_IDX_ONE;
                        idle_q <= 1'b0;
                        if (MAT_SCALE == 1) begin
                            state_q     <= S_DRAIN;
                            rd_q        <= '0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b1;
                        end else begin
                            state_q <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    wr_q <= wr_q + C_IDX_ONE;
                    if (wr_q == C_LAST_IDX) begin
                        state_q     <= S_DRAIN;
                        rd_q        <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        if (out_last_q) begin
                            state_q     <= S_IDLE;
                            wr_q        <= '0;
                            rd_q        <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            idle_q      <= 1'b1;
                        end else begin
                            rd_q       <= rd_q + C_IDX_ONE;
                            out_last_q <= ((rd_q + C_IDX_ONE) == C_LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    wr_q        <= '0;
                    rd_q        <= '0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    idle_q      <= 1'b1;
                end
            endcase
        end
    end

    assign rd_word_d = buf_q[rd_q];

    if (OUT_WIDTH < IN_WIDTH) begin : g_sat
        localparam logic signed [IN_WIDTH-1:0] C_SAT_MAX =
            {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        localparam logic signed [IN_WIDTH-1:0] C_SAT_MIN =
            {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

        // Signed clamp of the word under the read pointer.
        always_comb begin
            sat_data_d = rd_word_d[OUT_WIDTH-1:0];
            sat_flag_d = 1'b0;
            if (rd_word_d > C_SAT_MAX) begin
                sat_data_d = C_SAT_MAX[OUT_WIDTH-1:0];
                sat_flag_d = 1'b1;
            end else if (rd_word_d < C_SAT_MIN) begin
                sat_data_d = C_SAT_MIN[OUT_WIDTH-1:0];
                sat_flag_d = 1'b1;
            end
        end
    end else begin : g_no_sat
        assign sat_data_d = rd_word_d[OUT_WIDTH-1:0];
        assign sat_flag_d = 1'b0;
    end

    // Data and flag are forced to zero outside a valid beat so reset shows zeros.
    assign out_data    = out_valid_q ? sat_data_d : '0;
    assign out_sat     = out_valid_q & sat_flag_d;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign idle        = idle_q;
    assign err_overrun = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mvm_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_mvm_result_drain
// Description : Directed bench for mvm_result_drain with a scoreboard of
//               expected saturated words, checked on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mvm_result_drain;

    localparam int MAT_SCALE = 3;
    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 8;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b1;
    logic                 done_in   = 1'b0;
    logic                 out_ready = 1'b0;
    logic [IN_WIDTH-1:0]  y_in      = '0;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 out_sat;
    logic                 idle;
    logic                 err_overrun;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t        = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       sat;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   hs[$];

    mvm_result_drain #(
        .MAT_SCALE (MAT_SCALE),
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .done_in     (done_in),
        .y_in        (y_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_sat     (out_sat),
        .idle        (idle),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected word after signed clamp to 8 bits.
    task automatic push(input int v, input logic last);
        exp_t e;
        if (v > 127) begin
            e.data = 8'd127;
            e.sat  = 1'b1;
        end else if (v < -128) begin
            e.data = 8'h80;
            e.sat  = 1'b1;
        end else begin
            e.data = 8'(v);
            e.sat  = 1'b0;
        end
        e.last = last;
        sb.push_back(e);
    endtask

    // One clock cycle: drive inputs, score any handshake, advance past the edge.
    task automatic step(input logic d, input int y, input logic rdy);
        exp_t e;
        done_in   = d;
        y_in      = 16'(y);
        out_ready = rdy;
        if (out_valid && rdy) begin
            hs.push_back(cyc);
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed word %0d, expected no word", out_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("word_data", {24'd0, out_data}, {24'd0, e.data});
                chk("word_sat",  {31'd0, out_sat},  {31'd0, e.sat});
                chk("word_last", {31'd0, out_last}, {31'd0, e.last});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1);
    endtask

    task automatic send_job(input int a, input int b, input int c);
        push(a, 1'b0);
        push(b, 1'b0);
        push(c, 1'b1);
        step(1'b1, a, 1'b1);
        step(1'b0, b, 1'b1);
        step(1'b0, c, 1'b1);
    endtask

    // Three handshakes expected in consecutive cycles starting at t0.
    task automatic check_hs(input string tag, input int t0);
        chk({tag, "_count"}, hs.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < hs.size()) chk({tag, "_cycle"}, hs[i], t0 + i);
        end
        hs.delete();
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #2;
        reset = 1'b0;
        #1;
        chk("rst_idle",  {31'd0, idle},        1);
        chk("rst_valid", {31'd0, out_valid},   0);
        chk("rst_data",  {24'd0, out_data},    0);
        chk("rst_last",  {31'd0, out_last},    0);
        chk("rst_sat",   {31'd0, out_sat},     0);
        chk("rst_err",   {31'd0, err_overrun}, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_steps(3);

        // Basic stream
        hs.delete();
        t = cyc;
        send_job(5, -7, 100);
        chk("basic_idle_busy", {31'd0, idle},      0);
        chk("basic_valid",     {31'd0, out_valid}, 1);
        idle_steps(3);
        chk("basic_idle_back", {31'd0, idle},      1);
        chk("basic_valid_off", {31'd0, out_valid}, 0);
        check_hs("basic_hs", t + 3);

        // Saturation
        idle_steps(2);
        t = cyc;
        send_job(300, -129, 127);
        idle_steps(3);
        check_hs("sat_hs", t + 3);

        // Backpressure
        idle_steps(2);
        t = cyc;
        send_job(5, -7, 100);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 1);
            chk("bp_data",  {24'd0, out_data},  5);
            step(1'b0, 0, 1'b0);
        end
        idle_steps(3);
        check_hs("bp_hs", t + 7);
        chk("bp_idle", {31'd0, idle}, 1);

        // Back-to-back jobs
        idle_steps(2);
        t = cyc;
        send_job(5, -7, 100);
        idle_steps(3);
        check_hs("b2b_hs1", t + 3);
        send_job(-1, 0, 1);
        idle_steps(3);
        check_hs("b2b_hs2", t + 9);
        chk("b2b_err", {31'd0, err_overrun}, 0);

        // Overrun, including a done pulse on the final handshake edge
        idle_steps(2);
        t = cyc;
        send_job(5, -7, 100);
        chk("ovr_err_before", {31'd0, err_overrun}, 0);
        step(1'b0, 0, 1'b1);
        step(1'b1, 0, 1'b1);
        chk("ovr_err_set", {31'd0, err_overrun}, 1);
        step(1'b1, 0, 1'b1);
        chk("ovr_last_done_rejected", {31'd0, idle}, 1);
        chk("ovr_err_sticky", {31'd0, err_overrun}, 1);
        check_hs("ovr_hs", t + 3);
        idle_steps(4);
        chk("ovr_no_job",     {31'd0, out_valid},   0);
        chk("ovr_no_words",   hs.size(),            0);
        chk("ovr_err_hold",   {31'd0, err_overrun}, 1);

        // Reset during capture discards the job
        t = cyc;
        step(1'b1, 9, 1'b1);
        chk("rstcap_busy", {31'd0, idle}, 0);
        reset = 1'b0;
        #1;
        chk("rstcap_idle",  {31'd0, idle},        1);
        chk("rstcap_valid", {31'd0, out_valid},   0);
        chk("rstcap_err",   {31'd0, err_overrun}, 0);
        step(1'b0, 0, 1'b1);
        reset = 1'b1;
        idle_steps(8);
        send_job(1, 2, 3);
        idle_steps(3);
        check_hs("rstcap_hs", t + 13);
        chk("rstcap_err_after", {31'd0, err_overrun}, 0);

        // Reset during drain drops out_valid without a clock edge
        idle_steps(2);
        step(1'b1, 7, 1'b0);
        step(1'b0, 8, 1'b0);
        step(1'b0, 9, 1'b0);
        chk("rstdrn_valid_pre", {31'd0, out_valid}, 1);
        chk("rstdrn_data_pre",  {24'd0, out_data},  7);
        reset = 1'b0;
        #1;
        chk("rstdrn_valid", {31'd0, out_valid}, 0);
        chk("rstdrn_data",  {24'd0, out_data},  0);
        chk("rstdrn_idle",  {31'd0, idle},      1);
        step(1'b0, 0, 1'b1);
        reset = 1'b1;
        idle_steps(4);
        chk("rstdrn_no_words", hs.size(), 0);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
